// File: rtl/bicubic_mult_stage1_pipe.sv
// Stage-1 bicubic coefficient multiplier: CH signed pixels per beat are scaled by a
// table coefficient and carried through a LATENCY-deep valid/ready pipeline.
module bicubic_mult_stage1_pipe #(
  parameter int CH      = 4,
  parameter int PIX_W   = 9,
  parameter int PROD_W  = 24,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CH*3-1:0]       in_weight,
  input  logic [CH*PIX_W-1:0]   in_pixel,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH*PROD_W-1:0]  out_product,
  output logic [TAG_W-1:0]      out_tag
);

  generate
    if (PROD_W < PIX_W + 12) begin : g_bad_prod_w
      $error("PROD_W must be at least PIX_W+12");
    end
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $error("LATENCY must be within 1..4");
    end
  endgenerate

  function automatic logic signed [11:0] coef_lut(input logic [2:0] idx);
    logic signed [11:0] c;
    case (idx)
      3'd0:    c = -12'sd21;
      3'd1:    c = -12'sd135;
      3'd2:    c = -12'sd147;
      3'd3:    c = -12'sd225;
      3'd4:    c = 12'sd235;
      3'd5:    c = 12'sd873;
      3'd6:    c = 12'sd1535;
      3'd7:    c = 12'sd1981;
      default: c = 12'sd0;
    endcase
    return c;
  endfunction

  logic [CH*PROD_W-1:0] prod_s;

  // Both operands are sign-extended to PROD_W first, so the product is exact.
  for (genvar k = 0; k < CH; k++) begin : g_mul
    logic signed [PIX_W-1:0]  pix_s;
    logic signed [PROD_W-1:0] pix_ext_s;
    logic signed [PROD_W-1:0] coef_ext_s;
    assign pix_s      = in_pixel[k*PIX_W +: PIX_W];
    assign pix_ext_s  = PROD_W'(pix_s);
    assign coef_ext_s = PROD_W'(coef_lut(in_weight[3*k +: 3]));
    assign prod_s[k*PROD_W +: PROD_W] = pix_ext_s * coef_ext_s;
  end

  logic [LATENCY-1:0]   v_q, v_d;
  logic [LATENCY-1:0]   rdy_s;
  logic [CH*PROD_W-1:0] prod_q [LATENCY];
  logic [CH*PROD_W-1:0] prod_d [LATENCY];
  logic [TAG_W-1:0]     tag_q  [LATENCY];
  logic [TAG_W-1:0]     tag_d  [LATENCY];

  // A stage may load when the stage after it moves or when it is empty itself.
  always_comb begin
    logic r;
    rdy_s = '0;
    r     = out_ready;
    for (int i = LATENCY - 1; i >= 0; i--) begin
      r        = r | ~v_q[i];
      rdy_s[i] = r;
    end
  end

  always_comb begin
    v_d    = v_q;
    prod_d = prod_q;
    tag_d  = tag_q;
    if (rdy_s[0]) begin
      v_d[0]    = in_valid;
      prod_d[0] = prod_s;
      tag_d[0]  = in_tag;
    end
    for (int i = 1; i < LATENCY; i++) begin
      if (rdy_s[i]) begin
        v_d[i]    = v_q[i-1];
        prod_d[i] = prod_q[i-1];
        tag_d[i]  = tag_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        prod_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      v_q    <= v_d;
      prod_q <= prod_d;
      tag_q  <= tag_d;
    end
  end

  assign in_ready    = rdy_s[0];
  assign out_valid   = v_q[LATENCY-1];
  assign out_product = prod_q[LATENCY-1];
  assign out_tag     = tag_q[LATENCY-1];

endmodule

// File: tb/tb_bicubic_mult_stage1_pipe.sv
// Bench for bicubic_mult_stage1_pipe: four instances (various CH/LATENCY) checked every
// cycle against a queue-based reference of accepted beats and their acceptance cycle.
module tb_bicubic_mult_stage1_pipe;

  localparam int NI = 4;

  function automatic int ch_of(input int g);
    case (g)
      0:       return 4;
      1:       return 4;
      2:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic int lat_of(input int g);
    case (g)
      0:       return 2;
      1:       return 1;
      2:       return 3;
      default: return 4;
    endcase
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iv_s  [NI];
  logic        ir_s  [NI];
  logic        ov_s  [NI];
  logic        or_s  [NI];
  logic [35:0] pix_s [NI];
  logic [11:0] w_s   [NI];
  logic [7:0]  tin_s [NI];
  logic [7:0]  tout_s[NI];
  logic [95:0] prod_s[NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int C = ch_of(g);
    localparam int L = lat_of(g);
    logic [C*24-1:0] p;
    bicubic_mult_stage1_pipe #(.CH(C), .PIX_W(9), .PROD_W(24), .LATENCY(L), .TAG_W(8)) u_dut (
      .clk(clk), .rst(rst), .in_valid(iv_s[g]), .in_ready(ir_s[g]),
      .in_weight(w_s[g][C*3-1:0]), .in_pixel(pix_s[g][C*9-1:0]), .in_tag(tin_s[g]),
      .out_valid(ov_s[g]), .out_ready(or_s[g]), .out_product(p), .out_tag(tout_s[g]));
    assign prod_s[g] = 96'(p);
  end

  typedef struct {
    logic [95:0] prod;
    logic [7:0]  tag;
    int          t;
    bit          has_lit;
    logic [95:0] lit;
  } beat_t;

  beat_t       mq [NI][$];
  int          coef_t [8] = '{-21, -135, -147, -225, 235, 873, 1535, 1981};
  int          t3v    [8] = '{5376, 34560, 37632, 57600, -60160, -223488, -392960, -507136};
  int          cyc = 0, checks = 0, errors = 0;
  int          pv [NI][4];
  int          wv [NI][4];
  logic [7:0]  tv [NI];
  bit          ivv[NI], orv[NI], rnd[NI];
  bit          rstv, lit_en, fire0, just_rst, armed;
  logic [95:0] lit_v;

  function automatic logic [95:0] pack4(input int a, input int b, input int c, input int d);
    return {24'(d), 24'(c), 24'(b), 24'(a)};
  endfunction

  function automatic logic [95:0] exp_prod(input int g);
    logic [95:0] r;
    r = 96'd0;
    for (int k = 0; k < ch_of(g); k++) r[k*24 +: 24] = 24'(pv[g][k] * coef_t[wv[g][k]]);
    return r;
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, req);
    end
  endtask

  task automatic rand_beat0(input logic [7:0] tag);
    for (int k = 0; k < 4; k++) begin
      pv[0][k] = int'($urandom_range(511)) - 256;
      wv[0][k] = int'($urandom_range(7));
    end
    tv[0] = tag;
  endtask

  // One clock: drive, check against the reference, then advance the reference.
  task automatic step();
    @(negedge clk);
    cyc++;
    for (int g = 0; g < NI; g++) begin
      if (rnd[g]) begin
        ivv[g] = 1'($urandom_range(1));
        orv[g] = ($urandom_range(3) != 0);
        for (int k = 0; k < 4; k++) begin
          pv[g][k] = int'($urandom_range(511)) - 256;
          wv[g][k] = int'($urandom_range(7));
        end
        tv[g] = 8'($urandom);
      end
    end
    rst = rstv;
    for (int g = 0; g < NI; g++) begin
      iv_s[g]  = ivv[g];
      or_s[g]  = orv[g];
      tin_s[g] = tv[g];
      for (int k = 0; k < 4; k++) begin
        pix_s[g][k*9 +: 9] = 9'(pv[g][k]);
        w_s[g][k*3 +: 3]   = 3'(wv[g][k]);
      end
    end
    #1;
    if (armed) begin
      for (int g = 0; g < NI; g++) begin
        bit exp_ir, exp_ov;
        exp_ir = (mq[g].size() < lat_of(g)) || orv[g];
        exp_ov = (mq[g].size() > 0) && (cyc - mq[g][0].t >= lat_of(g));
        check($sformatf("in_ready[%0d]", g), 96'(ir_s[g]), 96'(exp_ir));
        check($sformatf("out_valid[%0d]", g), 96'(ov_s[g]), 96'(exp_ov));
        if (just_rst) begin
          check($sformatf("rst_product[%0d]", g), prod_s[g], 96'd0);
          check($sformatf("rst_tag[%0d]", g), 96'(tout_s[g]), 96'd0);
        end
        if (exp_ov && ov_s[g] === 1'b1) begin
          check($sformatf("product[%0d]", g), prod_s[g], mq[g][0].prod);
          check($sformatf("tag[%0d]", g), 96'(tout_s[g]), 96'(mq[g][0].tag));
          if (mq[g][0].has_lit) check($sformatf("literal[%0d]", g), prod_s[g], mq[g][0].lit);
        end
      end
    end
    just_rst = 1'b0;
    fire0    = 1'b0;
    for (int g = 0; g < NI; g++) begin
      if (rstv) begin
        mq[g].delete();
      end else begin
        if (ov_s[g] === 1'b1 && or_s[g] && mq[g].size() > 0) void'(mq[g].pop_front());
        if (iv_s[g] && ir_s[g] === 1'b1) begin
          beat_t b;
          b.prod    = exp_prod(g);
          b.tag     = tv[g];
          b.t       = cyc;
          b.has_lit = (g == 0) && lit_en;
          b.lit     = lit_v;
          mq[g].push_back(b);
          if (g == 0) fire0 = 1'b1;
        end
      end
    end
    if (rstv) begin
      just_rst = 1'b1;
      armed    = 1'b1;
    end
  endtask

  initial begin
    int n;
    armed = 1'b0; just_rst = 1'b0; lit_en = 1'b0; lit_v = 96'd0;
    for (int g = 0; g < NI; g++) begin
      rnd[g] = (g != 0); ivv[g] = 1'b1; orv[g] = 1'b1; tv[g] = 8'h3C;
      for (int k = 0; k < 4; k++) begin pv[g][k] = 77; wv[g][k] = k; end
    end
    // Reset held two cycles with valid input that must be ignored.
    rstv = 1'b1;
    step(); step();
    rstv = 1'b0; ivv[0] = 1'b0;
    step();

    // Single beat with hand-computed products.
    pv[0] = '{10, -1, 255, -256}; wv[0] = '{0, 3, 7, 6}; tv[0] = 8'hA5;
    lit_v = pack4(-210, 225, 505155, -392960); lit_en = 1'b1; ivv[0] = 1'b1;
    step();
    check("t2_accept", 96'(fire0), 96'd1);
    ivv[0] = 1'b0; lit_en = 1'b0;
    repeat (4) step();

    // Full coefficient sweep at pixel -256, back to back.
    for (int j = 0; j < 8; j++) begin
      for (int k = 0; k < 4; k++) begin pv[0][k] = -256; wv[0][k] = (j + k) % 8; end
      lit_v = pack4(t3v[j % 8], t3v[(j + 1) % 8], t3v[(j + 2) % 8], t3v[(j + 3) % 8]);
      tv[0] = 8'(j); lit_en = 1'b1; ivv[0] = 1'b1;
      step();
      check("t3_accept", 96'(fire0), 96'd1);
    end
    ivv[0] = 1'b0; lit_en = 1'b0;
    repeat (4) step();

    // Eight beats with a five-cycle downstream stall.
    n = 0;
    for (int j = 0; j < 8; j++) begin
      int tries;
      rand_beat0(8'(8'h40 + j));
      ivv[0] = 1'b1;
      tries  = 0;
      do begin
        orv[0] = !(n >= 2 && n < 7);
        step();
        n++; tries++;
      end while (!fire0 && tries < 40);
      if (!fire0) check("t4_accept_timeout", 96'd0, 96'd1);
    end
    ivv[0] = 1'b0; orv[0] = 1'b1;
    repeat (6) step();
    check("t4_drained", 96'(mq[0].size()), 96'd0);

    // Fill the pipe, then reset it with beats in flight.
    orv[0] = 1'b0;
    for (int j = 0; j < 4; j++) begin rand_beat0(8'(8'h80 + j)); ivv[0] = 1'b1; step(); end
    check("t5_full", 96'(mq[0].size()), 96'd2);
    rstv = 1'b1;
    step();
    rstv = 1'b0; ivv[0] = 1'b0; orv[0] = 1'b1;
    step();
    rand_beat0(8'h99); ivv[0] = 1'b1;
    step();
    check("t5_accept", 96'(fire0), 96'd1);
    ivv[0] = 1'b0;
    repeat (5) step();
    check("t5_drained", 96'(mq[0].size()), 96'd0);

    // Random traffic on every instance, then drain.
    rnd[0] = 1'b1;
    repeat (3000) step();
    for (int g = 0; g < NI; g++) begin rnd[g] = 1'b0; ivv[g] = 1'b0; orv[g] = 1'b1; end
    repeat (8) step();
    for (int g = 0; g < NI; g++) check($sformatf("final_drain[%0d]", g), 96'(mq[g].size()), 96'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
